// File: rtl/multdiv_sequencer.sv
// Control FSM for the iterative multiply/divide datapath: load, step ITERS times, report.
// Optional macro EARLY_TERM_EN: multiply may finish early when step_done is raised in RUN.
module multdiv_sequencer #(
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             step_done,
    output logic             op_load,
    output logic             op_step,
    output logic             op_is_div,
    output logic             busy,
    output logic             stall,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic [CNT_W-1:0] iter_count
);

    // state | meaning
    // IDLE  | waiting for a start pulse
    // LOAD  | operand registers load (1 cycle)
    // RUN   | one datapath iteration per cycle
    // DONE  | result ready pulse, exception qualified here (1 cycle)
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_d;
    logic             is_div_d;
    logic             exc_q, exc_d;
    logic             start_evt, conflict_evt, early_term;

    assign start_evt    = ctrl_MULT ^ ctrl_DIV;
    assign conflict_evt = ctrl_MULT & ctrl_DIV;

`ifdef EARLY_TERM_EN
    assign early_term = step_done & ~op_is_div;
`else
    logic unused_step_done;
    assign unused_step_done = step_done;
    assign early_term       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            iter_count <= '0;
            op_is_div  <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_count <= iter_d;
            op_is_div  <= is_div_d;
            exc_q      <= exc_d;
        end
    end

    // Start pulses pre-empt whatever is in flight, including the DONE cycle.
    always_comb begin
        state_d  = state_q;
        iter_d   = iter_count;
        is_div_d = op_is_div;
        exc_d    = exc_q;
        if (conflict_evt) begin
            state_d = S_DONE;
            exc_d   = 1'b1;
        end else if (start_evt) begin
            state_d  = S_LOAD;
            is_div_d = ctrl_DIV;
            iter_d   = '0;
            exc_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_LOAD: begin
                    if (op_is_div && divisor_zero) begin
                        state_d = S_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (early_term || iter_count == LAST_ITER) begin
                        state_d = S_DONE;
                    end else begin
                        iter_d = iter_count + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign op_load        = (state_q == S_LOAD);
    assign op_step        = (state_q == S_RUN);
    assign busy           = op_load | op_step;
    assign stall          = busy;
    assign data_resultRDY = (state_q == S_DONE);
    assign data_exception = data_resultRDY & exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed scenarios plus random start traffic against a cycle-age model.
module tb_multdiv_sequencer;
    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ctrl_MULT = 1'b0;
    logic             ctrl_DIV = 1'b0;
    logic             divisor_zero = 1'b0;
    logic             step_done = 1'b0;
    logic             op_load, op_step, op_is_div, busy, stall;
    logic             data_resultRDY, data_exception;
    logic [CNT_W-1:0] iter_count;

    multdiv_sequencer #(.ITERS(ITERS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .divisor_zero(divisor_zero), .step_done(step_done),
        .op_load(op_load), .op_step(op_step), .op_is_div(op_is_div),
        .busy(busy), .stall(stall), .data_resultRDY(data_resultRDY),
        .data_exception(data_exception), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_no   = 0;
    int rdy_at, rdy_cnt, iter_at_rdy, exc_at_rdy, stall_cnt, step_cnt;

    // Model: age = cycles since the last start (1 = load cycle); forced = unscheduled DONE cycle.
    int m_age, m_iter;
    bit m_forced, m_div, m_exc;

    function automatic void model_reset();
        m_age = 0; m_iter = 0; m_forced = 0; m_div = 0; m_exc = 0;
    endfunction

    function automatic void model_edge(bit m, bit d, bit dz, bit sd);
        bit is_done;
        bit early;
        is_done = m_forced || (m_age == ITERS + 2);
`ifdef EARLY_TERM_EN
        early = !m_div && sd;
`else
        early = sd && 1'b0;
`endif
        if (m && d) begin
            m_forced = 1; m_exc = 1; m_age = 0;
        end else if (m ^ d) begin
            m_age = 1; m_div = d; m_exc = 0; m_iter = 0; m_forced = 0;
        end else if (is_done) begin
            m_age = 0; m_forced = 0;
        end else if (m_age == 1) begin
            if (m_div && dz) begin
                m_forced = 1; m_exc = 1; m_age = 0;
            end else begin
                m_age = 2;
            end
        end else if (m_age >= 2) begin
            if (early) begin
                m_forced = 1; m_age = 0;
            end else begin
                m_age++;
                m_iter = (m_age - 2 < ITERS - 1) ? m_age - 2 : ITERS - 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic check_all();
        bit e_load, e_step, e_rdy;
        e_load = (m_age == 1);
        e_step = (m_age >= 2) && (m_age <= ITERS + 1);
        e_rdy  = m_forced || (m_age == ITERS + 2);
        chk("op_load", 32'(op_load), 32'(e_load));
        chk("op_step", 32'(op_step), 32'(e_step));
        chk("busy", 32'(busy), 32'(e_load | e_step));
        chk("stall", 32'(stall), 32'(e_load | e_step));
        chk("rdy", 32'(data_resultRDY), 32'(e_rdy));
        chk("exception", 32'(data_exception), 32'(e_rdy && m_exc));
        chk("op_is_div", 32'(op_is_div), 32'(m_div));
        chk("iter_count", 32'(iter_count), 32'(m_iter));
        if (data_resultRDY === 1'b1) begin
            rdy_cnt++;
            if (rdy_at < 0) begin
                rdy_at      = cyc_no;
                iter_at_rdy = int'(iter_count);
                exc_at_rdy  = int'(data_exception);
            end
        end
        if (stall === 1'b1) stall_cnt++;
        if (op_step === 1'b1) step_cnt++;
    endtask

    task automatic step_cyc(input bit m, input bit d);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        model_edge(m, d, divisor_zero, step_done);
        @(posedge clk);
        #1;
        ctrl_MULT = 0;
        ctrl_DIV  = 0;
        cyc_no++;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step_cyc(0, 0);
    endtask

    task automatic new_scenario();
        cyc_no = 0; rdy_at = -1; rdy_cnt = 0; iter_at_rdy = -1; exc_at_rdy = -1;
        stall_cnt = 0; step_cnt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        new_scenario();
        // Reset state
        #2;
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b1;
        idle_cycles(3);

        // Full multiply: RDY in cycle 34, 32 step cycles, stall cycles 1..33
        new_scenario();
        step_cyc(1, 0);
        idle_cycles(39);
        chk("mult_rdy_cycle", rdy_at, 34);
        chk("mult_iter_at_rdy", iter_at_rdy, ITERS - 1);
        chk("mult_exc_at_rdy", exc_at_rdy, 0);
        chk("mult_step_cycles", step_cnt, ITERS);
        chk("mult_stall_cycles", stall_cnt, ITERS + 1);

        // Divide by zero: RDY with exception in cycle 2
        new_scenario();
        divisor_zero = 1'b1;
        step_cyc(0, 1);
        idle_cycles(5);
        divisor_zero = 1'b0;
        chk("div0_rdy_cycle", rdy_at, 2);
        chk("div0_exc", exc_at_rdy, 1);
        chk("div0_steps", step_cnt, 0);

        // Conflicting start
        new_scenario();
        step_cyc(1, 1);
        idle_cycles(4);
        chk("conflict_rdy_cycle", rdy_at, 1);
        chk("conflict_exc", exc_at_rdy, 1);
        chk("conflict_stall", stall_cnt, 0);

        // MULT aborted by DIV in cycle 10
        new_scenario();
        step_cyc(1, 0);
        idle_cycles(9);
        step_cyc(0, 1);
        idle_cycles(40);
        chk("abort_rdy_cycle", rdy_at, 44);
        chk("abort_rdy_count", rdy_cnt, 1);

        // Reset asserted in cycle 15 of a divide
        new_scenario();
        step_cyc(0, 1);
        idle_cycles(14);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1; check_all();
        @(posedge clk); #1; check_all();
        rst = 1'b1;
        idle_cycles(40);
        chk("reset_rdy_count", rdy_cnt, 0);

        // Start during DONE goes straight to LOAD
        new_scenario();
        step_cyc(1, 1);
        step_cyc(1, 0);
        idle_cycles(36);
        chk("done_restart_rdy_count", rdy_cnt, 2);

        // step_done sampled at the end of cycle 5 of a multiply
        new_scenario();
        step_cyc(1, 0);
        idle_cycles(4);
        step_done = 1'b1;
        step_cyc(0, 0);
        step_done = 1'b0;
        idle_cycles(34);
`ifdef EARLY_TERM_EN
        chk("early_rdy_cycle", rdy_at, 6);
        chk("early_iter_at_rdy", iter_at_rdy, 3);
`else
        chk("early_rdy_cycle", rdy_at, 34);
        chk("early_iter_at_rdy", iter_at_rdy, ITERS - 1);
`endif

        // Random traffic
        new_scenario();
        for (int i = 0; i < 3000; i++) begin
            int r;
            divisor_zero = ($urandom_range(0, 3) == 0);
            step_done    = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 59);
            if (r == 0) step_cyc(1, 1);
            else if (r < 3) step_cyc(0, 1);
            else if (r < 5) step_cyc(1, 0);
            else step_cyc(0, 0);
        end
        divisor_zero = 1'b0;
        step_done    = 1'b0;
        idle_cycles(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
